// File: rtl/mod_mul_serial.sv
// ============================================================================
// Module   : mod_mul_serial
// Function : (op0 * op1) mod q, MSB-first interleaved shift-add, 1 bit/cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_mul_serial #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] op0_i,
   input  logic [DATA_WIDTH-1:0] op1_i,
   input  logic [DATA_WIDTH-1:0] q_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] res_o
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_WIDTH-1:0] op0;
   logic [DATA_WIDTH-1:0] op1;
   logic [DATA_WIDTH-1:0] q;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] res;
   logic [CNT_W-1:0]      cnt;

   logic                  load;
   logic                  step;
   logic                  last_step;

   logic [DATA_WIDTH:0]   q_ext;
   logic [DATA_WIDTH:0]   dbl;
   logic [DATA_WIDTH:0]   red1;
   logic [DATA_WIDTH:0]   add;
   logic [DATA_WIDTH:0]   red2;
   logic [DATA_WIDTH-1:0] acc_next;

   // One extra bit keeps 2*acc and t + op0 exact while acc, op0 < q.
   always_comb begin
      q_ext    = {1'b0, q};
      dbl      = {acc, 1'b0};
      red1     = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
      add      = op1[cnt] ? (red1 + {1'b0, op0}) : red1;
      red2     = (add >= q_ext) ? (add - q_ext) : add;
      acc_next = DATA_WIDTH'(red2);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last_step  = (cnt == '0);
      case (state)
         IDLE: begin
            if (valid_i) begin
               load       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (ready_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op0 <= '0;
         op1 <= '0;
         q   <= '0;
         acc <= '0;
         cnt <= '0;
         res <= '0;
      end else if (load) begin
         op0 <= op0_i;
         op1 <= op1_i;
         q   <= q_i;
         acc <= '0;
         cnt <= CNT_LAST;
      end else if (step) begin
         acc <= acc_next;
         cnt <= cnt - 1'b1;
         if (last_step) begin
            res <= acc_next;
         end
      end
   end

   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);
   assign res_o   = res;

endmodule

`default_nettype wire

// File: doc/mod_mul_serial.md
MOD_MUL_SERIAL -- requirements
Module: mod_mul_serial

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of operands, modulus and result.
- REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
- REQ-004 SHALL have port valid_i, input, 1 bit: upstream operand set valid.
- REQ-005 SHALL have port ready_o, output, 1 bit: block can accept an operand set.
- REQ-006 SHALL have port op0_i, input, DATA_WIDTH bits: multiplicand, typically the (a - b) mod q difference from the upstream subtractor.
- REQ-007 SHALL have port op1_i, input, DATA_WIDTH bits: multiplier (twiddle factor).
- REQ-008 SHALL have port q_i, input, DATA_WIDTH bits: modulus.
- REQ-009 SHALL have port valid_o, output, 1 bit: res_o valid.
- REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts the result.
- REQ-011 SHALL have port res_o, output, DATA_WIDTH bits: (op0 * op1) mod q, registered.

Function
- REQ-012 SHALL compute res = (op0 * op1) mod q by MSB-first interleaved shift-add, one op1 bit per cycle.
- REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
- REQ-014 SHALL drive ready_o = 1 only in IDLE and valid_o = 1 only in DONE, both decoded from the state register.
- REQ-015 In IDLE with valid_i = 1, SHALL register op0_i, op1_i and q_i, clear acc to 0, set bit counter cnt = DATA_WIDTH-1, and go to BUSY.
- REQ-016 In each BUSY cycle, SHALL apply the following steps, in order:
  - t = 2*acc;
  - if t >= q, then t = t - q;
  - if op1[cnt] = 1, then t = t + op0;
  - if t >= q, then t = t - q;
  - acc = t.
- REQ-017 SHALL use DATA_WIDTH+1-bit internal arithmetic for t, so no intermediate value overflows for q < 2^DATA_WIDTH.
- REQ-018 SHALL decrement cnt each BUSY cycle; after the cnt = 0 step it SHALL load res_o with the final acc and go to DONE.
- REQ-019 Latency: operand accepted at the end of cycle n SHALL give valid_o = 1 in cycle n+DATA_WIDTH+1 (exactly DATA_WIDTH BUSY cycles).
- REQ-020 In DONE, SHALL hold res_o and valid_o stable while ready_i = 0, and SHALL go to IDLE on the cycle edge where ready_i = 1.
- REQ-021 SHALL keep res_o holding the last result after leaving DONE, until the next DONE entry.
- REQ-022 SHALL NOT accept a new operand in the same cycle the result handshake completes; minimum initiation interval is DATA_WIDTH+2 cycles.
- REQ-023 SHALL ignore valid_i and input changes during BUSY and DONE; the latched operands are used.
- REQ-024 Defined-result precondition: 1 <= q < 2^DATA_WIDTH and op0, op1 < q.
- REQ-025 If the REQ-024 precondition is violated (including q = 0), res_o is unspecified, but latency and handshake SHALL be unchanged and the FSM SHALL NOT hang.
- REQ-026 If q = 1, SHALL return 0.

Reset
- REQ-027 rst_ni = 0 SHALL immediately force:
  - state = IDLE;
  - acc, cnt, latched operands and res_o = 0;
  - valid_o = 0 and ready_o = 1.
- REQ-028 Reset asserted during BUSY or DONE SHALL abort the operation with no result produced.
- REQ-029 After reset release, the first valid_i cycle SHALL be accepted normally.

Verification
- REQ-030 With DATA_WIDTH=32, q=3329, op0=1234, op1=17, ready_i=1: valid_o SHALL rise exactly 33 cycles after the accept edge with res_o=1004, then return to IDLE next cycle.
- REQ-031 With q=8380417, op0=op1=8380416: SHALL return res_o=1; with op0=0, op1=8380416: SHALL return res_o=0.
- REQ-032 Backpressure: hold ready_i=0 for 5 cycles in DONE; valid_o and res_o SHALL stay constant, then exactly one handshake SHALL occur when ready_i=1.
- REQ-033 Toggle valid_i and change op0_i/op1_i/q_i every cycle during BUSY: result SHALL equal that of the latched operands, and ready_o SHALL stay 0.
- REQ-034 Assert rst_ni=0 at BUSY cycle 10: valid_o=0, ready_o=1 and res_o=0 SHALL hold immediately. A new operation (q=3329, 3328*3328) SHALL then give 1.
- REQ-035 Randomised run of 10^4 operands with q in {3329, 7681, 8380417}: SHALL match a (op0*op1)%q reference model, with random ready_i and valid_i.
